// File: rtl/bambu_mem_master.sv
// bambu_mem_master
// Sequential initiator for the Bambu minimal memory protocol. It runs block
// read or block write commands of up to 2^LEN_W-1 beats against any responder
// that answers oe/we strobes with M_DataRdy. Write beats arrive on a
// valid/ready stream and read beats leave on one.
//
// Ports:
//   clock, reset                    rising-edge clock, async active-high reset
//   cmd_valid/cmd_ready             command handshake (ready only in IDLE)
//   cmd_write, cmd_addr, cmd_len    direction, start address, beat count
//   wr_data/wr_valid/wr_ready       write beat stream
//   rd_data/rd_valid/rd_ready       read beat stream
//   done                            one-cycle pulse at the end of a command
//   error                           sticky timeout flag, cleared on next command
//   Mout_*                          strobes, address, data and size to responder
//   M_Rdata_ram, M_DataRdy          responder read data and completion
//
// All outputs are registers loaded from the next-state values, so the
// responder sees glitch-free strobes and the async reset drops them at once.
module bambu_mem_master #(
    parameter int ADDR_W  = 7,
    parameter int DATA_W  = 8,
    parameter int SIZE_W  = 4,
    parameter int LEN_W   = 8,
    parameter int TIMEOUT = 1023
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic              done,
    output logic              error,
    output logic              Mout_oe_ram,
    output logic              Mout_we_ram,
    output logic [ADDR_W-1:0] Mout_addr_ram,
    output logic [DATA_W-1:0] Mout_Wdata_ram,
    output logic [SIZE_W-1:0] Mout_data_ram_size,
    input  logic [DATA_W-1:0] M_Rdata_ram,
    input  logic              M_DataRdy
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    // Last wait count before giving up: the strobe is held TIMEOUT cycles.
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WDATA  = 3'd1,
        ST_ACCESS = 3'd2,
        ST_RDOUT  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t              state_r, state_s;
    logic [ADDR_W-1:0]   addr_r, addr_s;
    logic                write_r, write_s;
    logic [LEN_W-1:0]    remaining_r, remaining_s;
    logic [DATA_W-1:0]   wdata_r, wdata_s;
    logic [DATA_W-1:0]   rd_data_s;
    logic                error_s;
    logic [WAIT_W-1:0]   wait_r, wait_s;
    logic                access_s;

    // Next-state and next-register computation for the command sequencer.
    always_comb begin
        state_s     = state_r;
        addr_s      = addr_r;
        write_s     = write_r;
        remaining_s = remaining_r;
        wdata_s     = wdata_r;
        rd_data_s   = rd_data;
        error_s     = error;
        wait_s      = {WAIT_W{1'b0}};   // cleared everywhere but ACCESS
        case (state_r)
            ST_IDLE: begin
                if (cmd_valid) begin
                    addr_s      = cmd_addr;
                    write_s     = cmd_write;
                    remaining_s = cmd_len;
                    error_s     = 1'b0;
                    if (cmd_len == {LEN_W{1'b0}}) begin
                        state_s = ST_DONE;
                    end else if (cmd_write) begin
                        state_s = ST_WDATA;
                    end else begin
                        state_s = ST_ACCESS;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WDATA: begin
                if (wr_valid) begin
                    wdata_s = wr_data;
                    state_s = ST_ACCESS;
                end else begin
                    state_s = ST_WDATA;
                end
            end
            ST_ACCESS: begin
                // Completion has priority over the timeout on the same cycle.
                if (M_DataRdy) begin
                    if (write_r) begin
                        addr_s      = addr_r + ADDR_W'(1);
                        remaining_s = remaining_r - LEN_W'(1);
                        state_s     = (remaining_r == LEN_W'(1)) ? ST_DONE : ST_WDATA;
                    end else begin
                        rd_data_s = M_Rdata_ram;
                        state_s   = ST_RDOUT;
                    end
                end else if (wait_r == WAIT_LAST) begin
                    error_s = 1'b1;
                    state_s = ST_DONE;
                end else begin
                    wait_s  = wait_r + WAIT_W'(1);
                    state_s = ST_ACCESS;
                end
            end
            ST_RDOUT: begin
                if (rd_ready) begin
                    addr_s      = addr_r + ADDR_W'(1);
                    remaining_s = remaining_r - LEN_W'(1);
                    state_s     = (remaining_r == LEN_W'(1)) ? ST_DONE : ST_ACCESS;
                end else begin
                    state_s = ST_RDOUT;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    assign access_s = (state_s == ST_ACCESS);

    // Sequencer state and datapath registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            addr_r      <= {ADDR_W{1'b0}};
            write_r     <= 1'b0;
            remaining_r <= {LEN_W{1'b0}};
            wdata_r     <= {DATA_W{1'b0}};
            wait_r      <= {WAIT_W{1'b0}};
        end else begin
            state_r     <= state_s;
            addr_r      <= addr_s;
            write_r     <= write_s;
            remaining_r <= remaining_s;
            wdata_r     <= wdata_s;
            wait_r      <= wait_s;
        end
    end

    // Registered outputs decoded from the next state; bus fields are zero outside ACCESS.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cmd_ready          <= 1'b1;
            wr_ready           <= 1'b0;
            rd_valid           <= 1'b0;
            rd_data            <= {DATA_W{1'b0}};
            done               <= 1'b0;
            error              <= 1'b0;
            Mout_oe_ram        <= 1'b0;
            Mout_we_ram        <= 1'b0;
            Mout_addr_ram      <= {ADDR_W{1'b0}};
            Mout_Wdata_ram     <= {DATA_W{1'b0}};
            Mout_data_ram_size <= {SIZE_W{1'b0}};
        end else begin
            cmd_ready          <= (state_s == ST_IDLE);
            wr_ready           <= (state_s == ST_WDATA);
            rd_valid           <= (state_s == ST_RDOUT);
            rd_data            <= rd_data_s;
            done               <= (state_s == ST_DONE);
            error              <= error_s;
            Mout_oe_ram        <= access_s & ~write_s;
            Mout_we_ram        <= access_s & write_s;
            Mout_addr_ram      <= access_s ? addr_s : {ADDR_W{1'b0}};
            Mout_Wdata_ram     <= (access_s & write_s) ? wdata_s : {DATA_W{1'b0}};
            Mout_data_ram_size <= access_s ? SIZE_W'(DATA_W) : {SIZE_W{1'b0}};
        end
    end

endmodule
